// File: rtl/dmem_block_mem.sv
// Block-organised data memory behind the data cache: 4-byte block refills and write-backs
// with a fixed LATENCY-cycle stall signalled on busywait. Define DMEM_STATS_EN for op counters.
module dmem_block_mem #(
  parameter int LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_count;
  logic [5:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_is_write;
  logic [7:0]  r_mem [256];
  logic [31:0] r_readdata;
  logic        w_commit;
  logic        w_req;
  logic [31:0] w_rd_word;

  assign w_req    = read | write;
  assign readdata = r_readdata;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_state_next = BUSY;
      BUSY:    if (r_count == 4'd0) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs: busywait mirrors the request in IDLE so the cache stalls in the request cycle
  always_comb begin
    busywait = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE:    busywait = w_req & ~reset;
      BUSY: begin
        busywait = ~reset;
        w_commit = (r_count == 4'd0);
      end
      default: busywait = 1'b0;
    endcase
  end

  // Byte lanes of the latched block; lane 0 is the lowest address
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_rd_word[8*gi +: 8] = r_mem[{r_addr, 2'(gi)}];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= 4'd0;
      r_addr     <= 6'd0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
      r_readdata <= 32'd0;
      for (int i = 0; i < 256; i++) r_mem[i] <= 8'd0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_addr     <= address;
        r_wdata    <= writedata;
        r_is_write <= write;
        r_count    <= 4'(LATENCY - 1);
      end else if (r_state == BUSY && r_count != 4'd0) begin
        r_count <= r_count - 4'd1;
      end
      if (w_commit) begin
        if (r_is_write) begin
          for (int b = 0; b < 4; b++) r_mem[{r_addr, 2'(b)}] <= r_wdata[8*b +: 8];
        end else begin
          r_readdata <= w_rd_word;
        end
      end
    end
  end

`ifdef DMEM_STATS_EN
  // Counters advance only at a real commit, so aborted ops are never counted
  always_ff @(posedge clock) begin
    if (reset) begin
      read_count  <= 16'd0;
      write_count <= 16'd0;
    end else if (w_commit) begin
      if (r_is_write && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      if (!r_is_write && read_count != 16'hFFFF) read_count <= read_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_block_mem.sv
// Directed-vector bench for dmem_block_mem: stall timing, byte ordering, write priority, reset abort.
module tb_dmem_block_mem;
  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [5:0]  address = 6'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        busywait;
`ifdef DMEM_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  dmem_block_mem #(.LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
`ifdef DMEM_STATS_EN
    ,
    .read_count  (read_count),
    .write_count (write_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    tick;
    check_eq("bw_in_reset", {31'd0, busywait}, 32'd0);
    tick;
    check_eq("rdata_after_reset", readdata, 32'd0);
    reset  = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    $display("reset applied");
  endtask

  // Raise a request, hold it until busywait falls, then drop it during the DONE cycle
  task automatic mem_op(input bit rd, input bit wr, input logic [5:0] a,
                        input logic [31:0] d, input string tag);
    int n;
    read      = rd;
    write     = wr;
    address   = a;
    writedata = d;
    #1;
    check_eq({tag, "_bw_same_cycle"}, {31'd0, busywait}, 32'd1);
    tick;
    n = 0;
    while (busywait === 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check_eq({tag, "_stall_cycles"}, n, LAT);
    read  = 1'b0;
    write = 1'b0;
    if (wr) exp_wr++;
    else    exp_rd++;
    tick;
    $display("op %s rd=%0d wr=%0d addr=%0d wdata=%h rdata=%h stall=%0d",
             tag, rd, wr, a, d, readdata, n);
  endtask

  initial begin
    do_reset;

    mem_op(1, 0, 6'd3, 32'h0, "rd3");
    check_eq("rd3_data", readdata, 32'h0);

    mem_op(0, 1, 6'd37, 32'h55667788, "wr37");
    mem_op(0, 1, 6'd10, 32'hDEADBEEF, "wr10");
    check_eq("wr_keeps_rdata", readdata, 32'h0);
    mem_op(1, 0, 6'd10, 32'h0, "rd10");
    check_eq("rd10_data", readdata, 32'hDEADBEEF);
    check_eq("rd10_byte40", {24'd0, readdata[7:0]},   32'hEF);
    check_eq("rd10_byte41", {24'd0, readdata[15:8]},  32'hBE);
    check_eq("rd10_byte42", {24'd0, readdata[23:16]}, 32'hAD);
    check_eq("rd10_byte43", {24'd0, readdata[31:24]}, 32'hDE);

    // Write-back then refill, the read raised in the cycle after busywait falls
    mem_op(0, 1, 6'd5, 32'h11223344, "wb5");
    mem_op(1, 0, 6'd37, 32'h0, "refill37");
    check_eq("refill37_data", readdata, 32'h55667788);
    mem_op(1, 0, 6'd5, 32'h0, "rd5");
    check_eq("rd5_data", readdata, 32'h11223344);

    mem_op(1, 1, 6'd2, 32'hA5A5A5A5, "both2");
    check_eq("both2_keeps_rdata", readdata, 32'h11223344);
    mem_op(1, 0, 6'd2, 32'h0, "rd2");
    check_eq("rd2_data", readdata, 32'hA5A5A5A5);

    // Reset lands on the second edge after the sample edge: the write must not commit
    write     = 1'b1;
    address   = 6'd7;
    writedata = 32'hCAFEF00D;
    tick;
    tick;
    reset = 1'b1;
    write = 1'b0;
    #1;
    check_eq("abort_bw_reset", {31'd0, busywait}, 32'd0);
    tick;
    check_eq("abort_bw_after_edge", {31'd0, busywait}, 32'd0);
    reset  = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    $display("op abort wr addr=7 wdata=cafef00d reset at E0+2");
    #1;
    check_eq("idle_bw_low", {31'd0, busywait}, 32'd0);
    mem_op(1, 0, 6'd7, 32'h0, "rd7");
    check_eq("rd7_after_abort", readdata, 32'h0);
    mem_op(1, 0, 6'd10, 32'h0, "rd10_cleared");
    check_eq("rd10_cleared_data", readdata, 32'h0);
    mem_op(0, 1, 6'd1, 32'h01020304, "wr1");
    mem_op(0, 1, 6'd63, 32'hFFEEDDCC, "wr63");
    mem_op(1, 0, 6'd63, 32'h0, "rd63");
    check_eq("rd63_data", readdata, 32'hFFEEDDCC);

`ifdef DMEM_STATS_EN
    check_eq("read_count", {16'd0, read_count}, exp_rd);
    check_eq("write_count", {16'd0, write_count}, exp_wr);
    check_eq("read_count_3", {16'd0, read_count}, 32'd3);
    check_eq("write_count_2", {16'd0, write_count}, 32'd2);
    do_reset;
    check_eq("read_count_rst", {16'd0, read_count}, 32'd0);
    check_eq("write_count_rst", {16'd0, write_count}, 32'd0);
`else
    do_reset;
`endif
    mem_op(1, 0, 6'd63, 32'h0, "rd63_rst");
    check_eq("rd63_rst_data", readdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
